// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side signal bundle of the decode stage
interface decode_stage_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PC_W-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [PC_W-1:0]  out_pc;
   logic [5:0]       opcode;
   logic [4:0]       rd;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [9:0]       funct;
   logic [14:0]      imm15;
   logic             uses_imm;
   logic [CNT_W-1:0] dec_count;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, rd, rs, rt, funct, imm15, uses_imm, dec_count
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rd, rs, rt, funct, imm15, uses_imm, dec_count
   );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - two-entry skid-buffered decode register with flush and delivery counter
module decode_stage #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave io
);
   // Instruction bit 15 carries no field, so only the other 31 bits are stored.
   logic             main_valid;
   logic [30:0]      main_word;
   logic [PC_W-1:0]  main_pc;
   logic             skid_valid;
   logic [30:0]      skid_word;
   logic [PC_W-1:0]  skid_pc;
   logic [CNT_W-1:0] count;
   logic [30:0]      in_word;
   logic             in_fire;
   logic             out_fire;

   assign in_word  = {io.in_instr[31:16], io.in_instr[14:0]};
   assign in_fire  = io.in_valid & ~skid_valid;
   assign out_fire = main_valid & io.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_word  <= '0;
         main_pc    <= '0;
         skid_valid <= 1'b0;
         skid_word  <= '0;
         skid_pc    <= '0;
         count      <= '0;
      end else begin
         if (out_fire)
            count <= count + 1'b1;
         if (io.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (out_fire) begin
            if (skid_valid) begin
               main_word  <= skid_word;
               main_pc    <= skid_pc;
               skid_valid <= 1'b0;
            end else if (in_fire) begin
               main_word  <= in_word;
               main_pc    <= io.in_pc;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (!main_valid) begin
            if (in_fire) begin
               main_valid <= 1'b1;
               main_word  <= in_word;
               main_pc    <= io.in_pc;
            end
         end else if (in_fire) begin
            // Main is stalled; the skid slot is known free because in_ready gated the transfer.
            skid_valid <= 1'b1;
            skid_word  <= in_word;
            skid_pc    <= io.in_pc;
         end
      end
   end

   assign io.in_ready  = ~skid_valid;
   assign io.out_valid = main_valid;
   assign io.out_pc    = main_pc;
   assign io.opcode    = main_word[30:25];
   assign io.rd        = main_word[24:20];
   assign io.rs        = main_word[19:15];
   assign io.rt        = main_word[14:10];
   assign io.funct     = main_word[9:0];
   assign io.imm15     = main_word[14:0];
   assign io.uses_imm  = main_word[30];
   assign io.dec_count = count;
endmodule
